// File: rtl/vmem_fill.sv
// Rectangle fill engine writing COLOR into video memory in raster order, with CPU write priority.
// Optional clipping to the visible framebuffer is enabled by defining VMEM_FILL_CLIP_EN.
module vmem_fill #(
  parameter int FB_W = 240,
  parameter int FB_H = 240
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [15:0] cfg_wdata_i,
  output logic [15:0] cfg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_waddr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_waddr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

`ifdef VMEM_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [8:0] FB_W9 = 9'(FB_W);
  localparam logic [8:0] FB_H9 = 9'(FB_H);

  state_t     state;
  logic [7:0] x0_q;
  logic [7:0] y0_q;
  logic [8:0] w_q;
  logic [8:0] h_q;
  logic [2:0] color_q;
  logic [8:0] cur_x;
  logic [8:0] cur_y;
  logic [8:0] col_cnt;
  logic [8:0] row_cnt;

  logic start_req;
  logic cfg_wr_ok;
  logic last_col;
  logic last_row;
  logic pix_we;
  logic unused_wdata;

  assign start_req    = cfg_we_i && (cfg_addr_i == 3'd5) && cfg_wdata_i[0];
  assign cfg_wr_ok    = cfg_we_i && (state == IDLE);
  assign last_col     = (col_cnt == w_q - 9'd1);
  assign last_row     = (row_cnt == h_q - 9'd1);
  assign pix_we       = !CLIP_EN || ((cur_x < FB_W9) && (cur_y < FB_H9));
  assign unused_wdata = ^cfg_wdata_i[15:9];

  // Geometry registers are frozen outside IDLE so a running fill cannot be disturbed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (cfg_wr_ok) begin
      case (cfg_addr_i)
        3'd0:    x0_q    <= cfg_wdata_i[7:0];
        3'd1:    y0_q    <= cfg_wdata_i[7:0];
        3'd2:    w_q     <= cfg_wdata_i[8:0];
        3'd3:    h_q     <= cfg_wdata_i[8:0];
        3'd4:    color_q <= cfg_wdata_i[2:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      3'd0:    cfg_rdata_o = {8'b0, x0_q};
      3'd1:    cfg_rdata_o = {8'b0, y0_q};
      3'd2:    cfg_rdata_o = {7'b0, w_q};
      3'd3:    cfg_rdata_o = {7'b0, h_q};
      3'd4:    cfg_rdata_o = {13'b0, color_q};
      3'd5:    cfg_rdata_o = {15'b0, busy_o};
      default: cfg_rdata_o = '0;
    endcase
  end

  // Fill FSM; a CPU write steals the vmem port for one cycle and the cursor holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cur_x        <= '0;
      cur_y        <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      vmem_we_o    <= 1'b0;
      vmem_waddr_o <= '0;
      vmem_wdata_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      vmem_we_o <= 1'b0;
      done_o    <= 1'b0;
      if (cpu_we_i) begin
        vmem_we_o    <= 1'b1;
        vmem_waddr_o <= cpu_waddr_i;
        vmem_wdata_o <= cpu_wdata_i;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            busy_o <= 1'b1;
            if (w_q == 9'd0 || h_q == 9'd0) begin
              state  <= FIN;
              done_o <= 1'b1;
            end else begin
              state   <= RUN;
              cur_x   <= {1'b0, x0_q};
              cur_y   <= {1'b0, y0_q};
              col_cnt <= '0;
              row_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (!cpu_we_i) begin
            vmem_we_o    <= pix_we;
            vmem_waddr_o <= {cur_y[7:0], cur_x[7:0]};
            vmem_wdata_o <= color_q;
            if (last_col) begin
              col_cnt <= '0;
              cur_x   <= {1'b0, x0_q};
              if (last_row) begin
                state  <= FIN;
                done_o <= 1'b1;
              end else begin
                row_cnt <= row_cnt + 9'd1;
                cur_y   <= cur_y + 9'd1;
              end
            end else begin
              col_cnt <= col_cnt + 9'd1;
              cur_x   <= cur_x + 9'd1;
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
